// File: rtl/moving_average_filter_if.sv
// Sample-stream bundle for the moving-average filter: strobed input sample,
// flush request, averaged output with its strobe and the window-full flag.
interface moving_average_filter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         i_ce;
    logic                         i_clear;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         o_ce;
    logic                         o_primed;

    modport master (
        output i_ce,
        output i_clear,
        output data_in,
        input  data_out,
        input  o_ce,
        input  o_primed
    );

    modport slave (
        input  i_ce,
        input  i_clear,
        input  data_in,
        output data_out,
        output o_ce,
        output o_primed
    );
endinterface

// File: rtl/moving_average_filter.sv
// N-tap boxcar averager (N = 2^LOG2_TAPS): running-sum accumulator over a ring-buffer history.
// Define MOVING_AVERAGE_ROUND_EN to round half-up instead of truncating toward -inf.
module moving_average_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_TAPS  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    moving_average_filter_if.slave   bus
);
    localparam int N      = 1 << LOG2_TAPS;
    localparam int ACC_W  = DATA_WIDTH + LOG2_TAPS;
    localparam int FILL_W = LOG2_TAPS + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    logic signed [DATA_WIDTH-1:0] hist [N];
    logic [LOG2_TAPS-1:0]         wp;
    logic [FILL_W-1:0]            fill;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_next;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [ACC_W-1:0]      oldest_ext;
    logic                         sum_ce;
    logic                         accept;
    logic                         primed;
    logic signed [DATA_WIDTH-1:0] avg;
    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic                         o_ce_q;

    assign accept = bus.i_ce && !bus.i_clear;
    assign primed = (fill == FILL_FULL);

    // While filling, the evicted sample reads as zero, so warm-up yields sum/N without clearing the buffer.
    always_comb begin
        sample_ext = {{LOG2_TAPS{bus.data_in[DATA_WIDTH-1]}}, bus.data_in};
        oldest_ext = '0;
        if (primed) begin
            oldest_ext = {{LOG2_TAPS{hist[wp][DATA_WIDTH-1]}}, hist[wp]};
        end
        acc_next = acc + sample_ext - oldest_ext;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.i_clear) begin
            acc    <= '0;
            wp     <= '0;
            fill   <= '0;
            sum_ce <= 1'b0;
        end else begin
            sum_ce <= accept;
            if (accept) begin
                acc <= acc_next;
                wp  <= wp + 1'b1;
                if (!primed) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // History has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            hist[wp] <= bus.data_in;
        end
    end

`ifdef MOVING_AVERAGE_ROUND_EN
    localparam int RND_W = ACC_W + 1;
    logic signed [RND_W-1:0] acc_rnd;

    // Guard bit keeps the half-LSB add from wrapping; the shifted result still fits DATA_WIDTH.
    assign acc_rnd = {acc[ACC_W-1], acc} + RND_W'(1 << (LOG2_TAPS - 1));
    assign avg     = acc_rnd[ACC_W-1:LOG2_TAPS];
`else
    assign avg = acc[ACC_W-1:LOG2_TAPS];
`endif

    // Output stage ignores clear so a strobe already in flight still emerges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q <= '0;
            o_ce_q     <= 1'b0;
        end else begin
            o_ce_q <= sum_ce;
            if (sum_ce) begin
                data_out_q <= avg;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.o_ce     = o_ce_q;
    assign bus.o_primed = primed;
endmodule

// File: tb/tb_moving_average_filter.sv
// Directed-vector bench for moving_average_filter at DATA_WIDTH=8, LOG2_TAPS=2.
module tb_moving_average_filter;
    logic clk;
    logic reset_n;
    int   total;
    int   fails;

`ifdef MOVING_AVERAGE_ROUND_EN
    localparam int EXP_TWO  = 1;
    localparam int EXP_NEG1 = 0;
`else
    localparam int EXP_TWO  = 0;
    localparam int EXP_NEG1 = -1;
`endif

    moving_average_filter_if #(.DATA_WIDTH(8)) bus ();

    moving_average_filter #(
        .DATA_WIDTH(8),
        .LOG2_TAPS (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        bus.i_ce    = 1'b0;
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
    endtask

    // Single isolated sample; returns with the bench in that sample's o_ce cycle.
    task automatic strobe(input logic signed [7:0] d);
        bus.i_ce    = 1'b1;
        bus.data_in = d;
        tick();
        bus.i_ce = 1'b0;
        tick();
    endtask

    initial begin
        int                  exp_w [5];
        logic signed [7:0]   smp   [5];
        total = 0;
        fails = 0;
        exp_w = '{1, 3, 6, 10, 14};
        smp   = '{8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd20};

        reset_n     = 1'b0;
        bus.i_ce    = 1'b0;
        bus.i_clear = 1'b0;
        bus.data_in = '0;
        repeat (3) tick();
        chk("rst_data", $signed(bus.data_out), 0);
        chk("rst_oce", bus.o_ce, 0);
        chk("rst_primed", bus.o_primed, 0);
        reset_n = 1'b1;
        tick();

        // Warm-up and steady state, back-to-back
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                bus.i_ce    = 1'b1;
                bus.data_in = smp[i];
            end else begin
                bus.i_ce = 1'b0;
            end
            tick();
            chk("warm_primed", bus.o_primed, (i >= 3));
            chk("warm_oce", bus.o_ce, (i >= 1 && i <= 5));
            if (i >= 1 && i <= 5) chk("warm_data", $signed(bus.data_out), exp_w[i-1]);
        end
        chk("warm_hold", $signed(bus.data_out), 14);

        // Rounding
        do_clear();
        strobe(8'sd2);
        chk("rnd_two_oce", bus.o_ce, 1);
        chk("rnd_two", $signed(bus.data_out), EXP_TWO);
        do_clear();
        strobe(-8'sd1);
        chk("rnd_neg1_oce", bus.o_ce, 1);
        chk("rnd_neg1", $signed(bus.data_out), EXP_NEG1);

        // Full scale both directions
        do_clear();
        bus.i_ce    = 1'b1;
        bus.data_in = 8'sd127;
        repeat (4) tick();
        bus.i_ce = 1'b0;
        tick();
        chk("fs_pos_oce", bus.o_ce, 1);
        chk("fs_pos", $signed(bus.data_out), 127);
        bus.i_ce    = 1'b1;
        bus.data_in = -8'sd128;
        repeat (4) tick();
        bus.i_ce = 1'b0;
        tick();
        chk("fs_neg_oce", bus.o_ce, 1);
        chk("fs_neg", $signed(bus.data_out), -128);
        tick();
        chk("fs_neg_done", bus.o_ce, 0);

        // Sparse strobes with 3 idle cycles between
        do_clear();
        for (int k = 1; k <= 4; k++) begin
            bus.i_ce    = 1'b1;
            bus.data_in = 8'sd40;
            tick();
            bus.i_ce = 1'b0;
            chk("sparse_gap1", bus.o_ce, 0);
            tick();
            chk("sparse_oce", bus.o_ce, 1);
            chk("sparse_data", $signed(bus.data_out), 10 * k);
            tick();
            chk("sparse_gap2", bus.o_ce, 0);
            chk("sparse_hold", $signed(bus.data_out), 10 * k);
            tick();
            chk("sparse_gap3", bus.o_ce, 0);
        end

        // Clear with a coincident sample
        do_clear();
        bus.i_ce    = 1'b1;
        bus.data_in = 8'sd100;
        repeat (4) tick();
        chk("clr_primed_pre", bus.o_primed, 1);
        bus.i_clear = 1'b1;
        bus.data_in = 8'sd50;
        tick();
        bus.i_clear = 1'b0;
        bus.data_in = 8'sd8;
        chk("clr_primed_post", bus.o_primed, 0);
        chk("clr_inflight_oce", bus.o_ce, 1);
        chk("clr_inflight_data", $signed(bus.data_out), 100);
        tick();
        bus.i_ce = 1'b0;
        chk("clr_dropped_oce", bus.o_ce, 0);
        chk("clr_dropped_hold", $signed(bus.data_out), 100);
        tick();
        chk("clr_next_oce", bus.o_ce, 1);
        chk("clr_next_data", $signed(bus.data_out), 2);

        // Reset mid-stream
        bus.i_ce    = 1'b1;
        bus.data_in = 8'sd60;
        tick();
        bus.i_ce = 1'b0;
        reset_n  = 1'b0;
        tick();
        chk("rstm_oce", bus.o_ce, 0);
        chk("rstm_data", $signed(bus.data_out), 0);
        chk("rstm_primed", bus.o_primed, 0);
        reset_n = 1'b1;
        tick();
        chk("rstm_oce_after", bus.o_ce, 0);
        strobe(8'sd4);
        chk("rstm_restart_oce", bus.o_ce, 1);
        chk("rstm_restart_data", $signed(bus.data_out), 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
